// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
// Holds the opcode constants, the 4-bit state encodings, the ALUOp / ALUSrcB /
// PCSource codes used by the controller, ALU_Control and the datapath muxes,
// and the packed control vector driven by the output decoder.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN adds the HALT state.
package multicycle_ctrl_fsm_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  // ALUSrcB codes
  localparam logic [1:0] ALUSRCB_RT     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  // PCSource codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_EXEC      = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_ADDI_WB   = 4'd12,
    S_HALT      = 4'd13
`else
    S_ADDI_WB   = 4'd12
`endif
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_ctrl_out_decode.sv
// Combinational state-to-control-vector decoder (Moore outputs).
// Ports:
//   state_i     current FSM state
//   mem_ready_i memory handshake; only gates IRWrite/PCWrite in FETCH
//   ctrl_o      full control vector for the datapath
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (HALT decodes to all-zero).
module ctrl_out_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Decode the control vector; everything defaults to 0 (IDLE/HALT value)
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR and PC only load on the cycle the fetch actually completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = ALUSRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_RT;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ALUSRCB_RT;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multi-cycle MIPS-subset CPU.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB, stalls on mem_ready_i, counts
// retired instructions.
// Ports:
//   clk_i, rst_i (async, active-low), start_i, Op_i[5:0], mem_ready_i
//   datapath controls: PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o,
//     MemWrite_o, IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
//     ALUSrcB_o[1:0], ALUOp_o[1:0], PCSource_o[1:0]
//   State_o[3:0] debug, Instr_cnt_o[CNT_W-1:0], Illegal_o
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN traps unknown opcodes in HALT.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       Op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             MemtoReg_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic [1:0]       PCSource_o,
  output logic [3:0]       State_o,
  output logic [CNT_W-1:0] Instr_cnt_o,
  output logic             Illegal_o
);

  state_e           state_q, state_d;
  logic             retire_s;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            ctrl_s;

  // Next-state and retire decision
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      S_IDLE:     state_d = start_i ? S_FETCH : S_IDLE;
      S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op_i)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      // IR is stable here, so Op_i still selects load vs store
      S_MEM_ADDR: state_d = (Op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR: begin
        if (mem_ready_i) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_MEM_WR;
        end
      end
      S_EXEC:      state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_IDLE;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // State register, retire counter and sticky illegal flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire_s) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (state_d == S_HALT) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign Illegal_o = illegal_q;
`else
  // State register and retire counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire_s) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign Illegal_o = 1'b0;
`endif

  ctrl_out_decode u_ctrl_out_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl_s)
  );

  assign PCWrite_o     = ctrl_s.pc_write;
  assign PCWriteCond_o = ctrl_s.pc_write_cond;
  assign IorD_o        = ctrl_s.iord;
  assign MemRead_o     = ctrl_s.mem_read;
  assign MemWrite_o    = ctrl_s.mem_write;
  assign IRWrite_o     = ctrl_s.ir_write;
  assign MemtoReg_o    = ctrl_s.mem_to_reg;
  assign RegDst_o      = ctrl_s.reg_dst;
  assign RegWrite_o    = ctrl_s.reg_write;
  assign ALUSrcA_o     = ctrl_s.alu_src_a;
  assign ALUSrcB_o     = ctrl_s.alu_src_b;
  assign ALUOp_o       = ctrl_s.alu_op;
  assign PCSource_o    = ctrl_s.pc_source;
  assign State_o       = state_q;
  assign Instr_cnt_o   = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm with hand-computed control vectors.
// Control vector order (16 bits, MSB first):
//   PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
//   RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
module tb_multicycle_ctrl_fsm;

  localparam logic [15:0] C_ZERO      = 16'h0000;
  localparam logic [15:0] C_FETCH_RDY = 16'h9410;
  localparam logic [15:0] C_FETCH_WT  = 16'h1010;
  localparam logic [15:0] C_DECODE    = 16'h0030;
  localparam logic [15:0] C_EXEC      = 16'h004C;
  localparam logic [15:0] C_R_WB      = 16'h0180;
  localparam logic [15:0] C_IMM_ALU   = 16'h0060;
  localparam logic [15:0] C_ADDI_WB   = 16'h0080;
  localparam logic [15:0] C_MEM_RD    = 16'h3000;
  localparam logic [15:0] C_MEM_WB    = 16'h0280;
  localparam logic [15:0] C_MEM_WR    = 16'h2800;
  localparam logic [15:0] C_BRANCH    = 16'h4045;
  localparam logic [15:0] C_JUMP      = 16'h8002;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [5:0]  Op_i;
  logic        mem_ready_i;
  logic        PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o;
  logic        IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
  logic [1:0]  ALUSrcB_o, ALUOp_o, PCSource_o;
  logic [3:0]  State_o;
  logic [31:0] Instr_cnt_o;
  logic        Illegal_o;
  logic [15:0] ctrl_s;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i),
    .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
    .PCSource_o(PCSource_o), .State_o(State_o), .Instr_cnt_o(Instr_cnt_o),
    .Illegal_o(Illegal_o)
  );

  always #5 clk_i = ~clk_i;

  assign ctrl_s = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
                   IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
                   ALUSrcB_o, ALUOp_o, PCSource_o};

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Check the current state and controls with the given mem_ready, then clock once
  task automatic cyc(input logic rdy, input logic [3:0] est, input logic [15:0] ectl, input string tag);
    mem_ready_i = rdy;
    #2;
    check_val({tag, "_state"}, {60'd0, State_o}, {60'd0, est});
    check_val({tag, "_ctrl"}, {48'd0, ctrl_s}, {48'd0, ectl});
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; Op_i = 6'd0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_state", {60'd0, State_o}, 64'd0);
    check_val("rst_ctrl", {48'd0, ctrl_s}, 64'd0);
    check_val("rst_cnt", {32'd0, Instr_cnt_o}, 64'd0);
    check_val("rst_illegal", {63'd0, Illegal_o}, 64'd0);
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'd0, C_ZERO, "idle");
    start_i = 1'b1;
    cyc(1'b0, 4'd0, C_ZERO, "idle_start");
    start_i = 1'b0;

    // R_TYPE then ADDI, zero-wait memory
    Op_i = 6'b000000;
    cyc(1'b1, 4'd1, C_FETCH_RDY, "r_fetch");
    cyc(1'b1, 4'd2, C_DECODE, "r_decode");
    cyc(1'b1, 4'd7, C_EXEC, "r_exec");
    cyc(1'b1, 4'd8, C_R_WB, "r_wb");
    Op_i = 6'b001000;
    cyc(1'b1, 4'd1, C_FETCH_RDY, "addi_fetch");
    cyc(1'b1, 4'd2, C_DECODE, "addi_decode");
    cyc(1'b1, 4'd11, C_IMM_ALU, "addi_exec");
    cyc(1'b1, 4'd12, C_ADDI_WB, "addi_wb");
    check_val("cnt_after_alu", {32'd0, Instr_cnt_o}, 64'd2);

    // LW with 3 fetch waits and 2 read waits: 10 cycles
    Op_i = 6'b100011;
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'd1, C_FETCH_WT, "lw_fetch_wait");
    cyc(1'b1, 4'd1, C_FETCH_RDY, "lw_fetch");
    cyc(1'b0, 4'd2, C_DECODE, "lw_decode");
    cyc(1'b1, 4'd3, C_IMM_ALU, "lw_addr");
    for (int i = 0; i < 2; i++) cyc(1'b0, 4'd4, C_MEM_RD, "lw_rd_wait");
    cyc(1'b1, 4'd4, C_MEM_RD, "lw_rd");
    check_val("lw_cnt_pre_wb", {32'd0, Instr_cnt_o}, 64'd2);
    cyc(1'b0, 4'd5, C_MEM_WB, "lw_wb");
    check_val("cnt_after_lw", {32'd0, Instr_cnt_o}, 64'd3);

    // BEQ then J
    Op_i = 6'b000100;
    cyc(1'b1, 4'd1, C_FETCH_RDY, "beq_fetch");
    cyc(1'b1, 4'd2, C_DECODE, "beq_decode");
    cyc(1'b1, 4'd9, C_BRANCH, "beq_branch");
    Op_i = 6'b000010;
    cyc(1'b1, 4'd1, C_FETCH_RDY, "j_fetch");
    cyc(1'b1, 4'd2, C_DECODE, "j_decode");
    cyc(1'b1, 4'd10, C_JUMP, "j_jump");
    check_val("cnt_after_br", {32'd0, Instr_cnt_o}, 64'd5);

    // Illegal opcode
    Op_i = 6'b111111;
    cyc(1'b1, 4'd1, C_FETCH_RDY, "ill_fetch");
    cyc(1'b1, 4'd2, C_DECODE, "ill_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
    check_val("ill_halt_flag", {63'd0, Illegal_o}, 64'd1);
    start_i = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'd13, C_ZERO, "ill_halt");
    start_i = 1'b0;
    check_val("ill_halt_flag_held", {63'd0, Illegal_o}, 64'd1);
`else
    check_val("ill_nop_state", {60'd0, State_o}, 64'd1);
    check_val("ill_nop_flag", {63'd0, Illegal_o}, 64'd0);
`endif
    check_val("ill_cnt", {32'd0, Instr_cnt_o}, 64'd5);

    // Restart from reset, retire one J, then abort an SW mid-wait
    rst_i = 1'b0;
    #2;
    check_val("rst2_state", {60'd0, State_o}, 64'd0);
    check_val("rst2_cnt", {32'd0, Instr_cnt_o}, 64'd0);
    check_val("rst2_illegal", {63'd0, Illegal_o}, 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    Op_i = 6'b000010;
    cyc(1'b0, 4'd0, C_ZERO, "idle_start2");
    start_i = 1'b0;
    cyc(1'b1, 4'd1, C_FETCH_RDY, "j2_fetch");
    cyc(1'b1, 4'd2, C_DECODE, "j2_decode");
    cyc(1'b1, 4'd10, C_JUMP, "j2_jump");
    check_val("cnt_after_j2", {32'd0, Instr_cnt_o}, 64'd1);
    Op_i = 6'b101011;
    start_i = 1'b1;
    cyc(1'b1, 4'd1, C_FETCH_RDY, "sw_fetch");
    cyc(1'b1, 4'd2, C_DECODE, "sw_decode");
    start_i = 1'b0;
    cyc(1'b1, 4'd3, C_IMM_ALU, "sw_addr");
    for (int i = 0; i < 2; i++) cyc(1'b0, 4'd6, C_MEM_WR, "sw_wr_wait");
    mem_ready_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    check_val("abort_state", {60'd0, State_o}, 64'd0);
    check_val("abort_memwrite", {63'd0, MemWrite_o}, 64'd0);
    check_val("abort_ctrl", {48'd0, ctrl_s}, 64'd0);
    check_val("abort_cnt", {32'd0, Instr_cnt_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multi-cycle version of the MIPS-subset CPU.
- Decodes the opcode held in the instruction register (IR).
- Sequences PC, memory, IR, register file and ALU muxes across FETCH/DECODE/EXECUTE/MEM/WB steps.
- Stalls on a memory-ready handshake and counts retired instructions.
- Replaces the single-cycle combinational control in the multi-cycle CPU top level.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous reset, active-low
start_i  input  1  leave IDLE and begin fetching; sampled only in IDLE
Op_i  input  6  opcode field, IR[31:26]
mem_ready_i  input  1  memory completes the current read/write this cycle
PCWrite_o  output  1  unconditional PC update
PCWriteCond_o  output  1  PC update if ALU zero (BEQ)
IorD_o  output  1  memory address select: 0=PC, 1=ALUOut
MemRead_o  output  1  memory read request
MemWrite_o  output  1  memory write request
IRWrite_o  output  1  load IR
MemtoReg_o  output  1  writeback data select: 0=ALUOut, 1=MDR
RegDst_o  output  1  write-register select: 0=rt, 1=rd
RegWrite_o  output  1  register file write enable
ALUSrcA_o  output  1  ALU A select: 0=PC, 1=rs
ALUSrcB_o  output  2  ALU B select: 00=rt, 01=4, 10=sign-extended imm, 11=imm<<2
ALUOp_o  output  2  00=add, 01=sub, 11=R-type funct decode
PCSource_o  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
State_o  output  4  current state encoding, for debug
Instr_cnt_o  output  CNT_W  retired-instruction count
Illegal_o  output  1  sticky illegal-opcode flag; tied 0 unless feature enabled

Behaviour:
- Opcodes: R_TYPE 000000, ADDI 001000, LW 100011, SW 101011, BEQ 000100, J 000010.
- Reset (rst_i low, asynchronous): state=IDLE, Instr_cnt_o=0, Illegal_o=0. All control outputs are 0 in IDLE.
- Outputs are Moore-decoded from the state register. Exception: IRWrite_o and PCWrite_o in FETCH are gated by mem_ready_i.
- States and transitions:
  - IDLE(0): start_i=1 -> FETCH; otherwise stay.
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready_i. mem_ready_i=1 -> DECODE; otherwise stay, holding all outputs stable.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch-target precompute). Next state by Op_i:
    - LW/SW -> MEM_ADDR
    - R_TYPE -> EXEC
    - ADDI -> ADDI_EXEC
    - BEQ -> BRANCH
    - J -> JUMP
    - other -> FETCH (no retire)
  - MEM_ADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEM_RD; SW -> MEM_WR.
  - MEM_RD(4): MemRead=1, IorD=1. Wait for mem_ready_i, then -> MEM_WB.
  - MEM_WB(5): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH, retire.
  - MEM_WR(6): MemWrite=1, IorD=1. Wait for mem_ready_i, then -> FETCH, retire.
  - EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=11 -> R_WB.
  - R_WB(8): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH, retire.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH, retire.
  - JUMP(10): PCWrite=1, PCSource=10 -> FETCH, retire.
  - ADDI_EXEC(11): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
  - ADDI_WB(12): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH, retire.
- Retire: Instr_cnt_o increments by 1 on the clock edge leaving the final state of an instruction. Wraps modulo 2^CNT_W.
- Latency with zero-wait memory (cycles FETCH through last state):
  - R_TYPE 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3.
  - Each extra wait cycle on a memory access adds exactly 1 cycle.
- MemRead_o/MemWrite_o stay asserted, with IorD stable, for every wait cycle. They are never both 1.
- start_i outside IDLE is ignored. Reset mid-instruction aborts immediately to IDLE with the counter cleared.
- mem_ready_i outside FETCH/MEM_RD/MEM_WR is ignored.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: an unknown Op_i in DECODE -> HALT(13). Illegal_o=1 (sticky). All control outputs 0 and no retire. HALT is left only by reset.
- Undefined: an unknown opcode returns to FETCH as a non-retiring no-op. HALT state is absent and Illegal_o is tied to 0.

Decomposition:
- Shared package holds:
  - opcode constants
  - 4-bit state encodings
  - ALUOp, ALUSrcB and PCSource code constants (also used by ALU_Control and the datapath muxes)
- One natural sub-module: ctrl_out_decode, a combinational state-to-control-vector decoder. The FSM next-state logic and the counter stay in the top module.

Test Plan:
- Reset low, then high with start_i=0 for 5 cycles -> State_o=0, all controls 0, Instr_cnt_o=0. start_i=1 -> FETCH next cycle.
- R_TYPE and ADDI, mem_ready_i=1 always -> States 1,2,7,8 then 1,2,11,12. RegWrite in R_WB with RegDst=1, in ADDI_WB with RegDst=0. Instr_cnt_o=2.
- LW with 3 wait cycles on fetch and 2 on read -> FETCH lasts 4 cycles with IRWrite/PCWrite high only on the last. MEM_RD lasts 3 cycles with MemRead=IorD=1. Total 10 cycles, then MEM_WB with MemtoReg=1.
- BEQ then J -> BRANCH: PCWriteCond=1, ALUOp=01, PCSource=01. JUMP: PCWrite=1, PCSource=10. 3 cycles each; count +2.
- Op_i=111111 in DECODE:
  - Feature off: -> FETCH with count unchanged, Illegal_o=0.
  - Feature on: -> HALT, Illegal_o=1, held through 10 cycles of start_i=1.
- Assert rst_i low mid-MEM_WR wait -> same-cycle asynchronous return to IDLE, MemWrite_o=0, Instr_cnt_o=0.
